// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and one-cycle access sequencer for datamemory
// Optional misalignment check enabled by defining DMEM_ARB_ALIGN_CHK_EN
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_req,
    output logic                  p0_gnt,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_funct3,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    output logic                  p1_gnt,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_funct3,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,

    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic                  last_grant;

    logic                  cmd_we;
    logic [DM_ADDRESS-1:0] cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [2:0]            cmd_funct3;
    logic                  cmd_port;
    logic                  cmd_err;

    logic                  any_req;
    logic                  win_port;
    logic                  grant;

    logic                  sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [2:0]            sel_funct3;
    logic                  sel_misal;

    logic                  in_access;
    logic [DATA_W-1:0]     resp_data;

    // Winner selection: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            win_port = ~last_grant;
        end else begin
            win_port = p1_req;
        end
        grant = any_req && (state == S_IDLE) && !reset;
    end

    assign p0_gnt = grant & ~win_port;
    assign p1_gnt = grant &  win_port;

    // Route the winning port's command fields toward the command registers
    always_comb begin
        sel_we     = win_port ? p1_we     : p0_we;
        sel_addr   = win_port ? p1_addr   : p0_addr;
        sel_wdata  = win_port ? p1_wdata  : p0_wdata;
        sel_funct3 = win_port ? p1_funct3 : p0_funct3;
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    // Word needs addr[1:0]==0, halfword needs addr[0]==0, bytes are always aligned
    always_comb begin
        sel_misal = 1'b0;
        if (sel_funct3[1:0] == 2'b10) begin
            sel_misal = (sel_addr[1:0] != 2'b00);
        end else if (sel_funct3[1:0] == 2'b01) begin
            sel_misal = sel_addr[0];
        end
    end
`else
    assign sel_misal = 1'b0;
`endif

    // Next state: IDLE moves to ACCESS on a grant, ACCESS always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (grant) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, round-robin pointer and command registers; the command is latched on grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_funct3 <= 3'b000;
            cmd_port   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_grant <= win_port;
                cmd_we     <= sel_we;
                cmd_addr   <= sel_addr;
                cmd_wdata  <= sel_wdata;
                cmd_funct3 <= sel_funct3;
                cmd_port   <= win_port;
                cmd_err    <= sel_misal;
            end
        end
    end

    // Memory strobes only in ACCESS; a flagged command keeps its slot but touches nothing
    assign in_access = (state == S_ACCESS);
    assign MemRead   = in_access & ~cmd_we & ~cmd_err;
    assign MemWrite  = in_access &  cmd_we & ~cmd_err;
    assign a         = in_access ? cmd_addr   : '0;
    assign wd        = in_access ? cmd_wdata  : '0;
    assign Funct3    = in_access ? cmd_funct3 : 3'b000;

    // Stores and flagged commands answer with zero data; loads return what memory gave
    assign resp_data = (cmd_we || cmd_err) ? '0 : rd;

    // Response pulse to the owning port; rdata holds until that port's next response
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= in_access & ~cmd_port;
            p1_rvalid <= in_access &  cmd_port;
            if (in_access && !cmd_port) begin
                p0_rdata <= resp_data;
            end
            if (in_access && cmd_port) begin
                p1_rdata <= resp_data;
            end
        end
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    // Misalignment flag travels with the response pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_err <= 1'b0;
            p1_err <= 1'b0;
        end else begin
            p0_err <= in_access & ~cmd_port & cmd_err;
            p1_err <= in_access &  cmd_port & cmd_err;
        end
    end
`else
    assign p0_err = 1'b0;
    assign p1_err = 1'b0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported datamemory block.
- Shares the memory between port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Requesters use a req/gnt handshake; the arbiter registers the winning command, drives MemRead/MemWrite/a/wd/Funct3 for exactly one cycle, and returns a registered response.
- Round-robin fairness between the two ports.

Parameters:
DM_ADDRESS  9   width of byte address presented to datamemory
DATA_W      32  data width

Ports:
clk          in   1           clock; all state updates on rising edge
reset        in   1           synchronous, active-high reset
p0_req       in   1           port 0 request; held with fields stable until p0_gnt
p0_gnt       out  1           port 0 request accepted this cycle (combinational)
p0_we        in   1           1 = store, 0 = load
p0_addr      in   DM_ADDRESS  byte address
p0_wdata     in   DATA_W      store data
p0_funct3    in   3           access size/sign, RISC-V load/store encoding
p0_rvalid    out  1           one-cycle response pulse (loads and stores)
p0_rdata     out  DATA_W      load data, valid with p0_rvalid
p0_err       out  1           misaligned-access flag, valid with p0_rvalid
p1_*         same set as p0_*, for port 1
MemRead      out  1           to datamemory
MemWrite     out  1           to datamemory
a            out  DM_ADDRESS  to datamemory
wd           out  DATA_W      to datamemory
Funct3       out  3           to datamemory
rd           in   DATA_W      from datamemory (already sign/zero-extended)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: IDLE, ACCESS.
- IDLE:
  - gnt is raised combinationally to the arbitration winner when any req is high.
  - On grant, latch we/addr/wdata/funct3 and the port id into the command registers; the next state is ACCESS.
- ACCESS:
  - MemRead = ~cmd_we and MemWrite = cmd_we; a/wd/Funct3 come from the command registers.
  - The memory writes on the falling clock edge inside this cycle.
  - rd is sampled at the closing rising edge.
  - The next state is always IDLE. No gnt is given in ACCESS.
- Response:
  - The cycle after ACCESS, the owning port's rvalid = 1 for exactly one cycle.
  - Load: rdata = captured rd. Store: rdata = 0.
  - rdata holds its value until the next response to that port.
  - The other port's rvalid stays 0.
- Latency and throughput:
  - Latency is fixed: req accepted in cycle N -> memory access in N+1 -> rvalid in N+2.
  - The arbiter may grant a new request in the same cycle as rvalid (IDLE), so peak throughput is one access per 2 cycles.
- Arbitration:
  - A single req wins.
  - If both are high, the port opposite last_grant wins; last_grant updates on every grant.
- Memory outputs are all 0 in IDLE, so there is no spurious access.
- Requester rules:
  - A requester may drop req before gnt (withdraw), with no effect.
  - Field changes while req=1 and gnt=0 are allowed; the values sampled in the grant cycle are the ones used.
- Reset (any state, including mid-ACCESS):
  - State = IDLE, last_grant = 1 (port 0 wins first tie).
  - Command registers = 0; all rvalid/err = 0; all rdata = 0; gnt = 0 while reset is high.
  - An in-flight access is dropped and gets no response. A write already in its ACCESS cycle may have reached memory.
- funct3 is passed through unmodified. Sizes are interpreted by datamemory.

Optional Feature:
Macro DMEM_ARB_ALIGN_CHK_EN.
- Defined:
  - In IDLE, the granted command is checked for misalignment: funct3[1:0]=2'b10 with addr[1:0]!=0, or funct3[1:0]=2'b01 with addr[0]=1.
  - A misaligned command is still granted and still passes through ACCESS, but MemRead and MemWrite are forced to 0 (no memory side effect).
  - Response timing is unchanged: rvalid at N+2 with err=1 and rdata=0.
  - Aligned accesses give err=0.
- Undefined: no check; p0_err/p1_err are tied 0; all accesses are issued as-is.

Test Plan:
- Reset, then p0 store: p0_req, we=1, addr=0x010, wdata=0xDEADBEEF, funct3=010 -> p0_gnt in cycle 0, MemWrite=1/a=0x010 in cycle 1, p0_rvalid=1/p0_rdata=0 in cycle 2; then p0 load from 0x010 -> p0_rdata=0xDEADBEEF at +2.
- Both ports request in the first cycle after reset -> p0 granted first, p1 granted in the IDLE cycle of p0's response; p1_rvalid 2 cycles after its grant; p0 never sees p1's pulse.
- Both ports hold req continuously for 8 grants -> grant sequence strictly alternates p0,p1,p0,p1,...; one grant per 2 cycles; MemRead/MemWrite never asserted in IDLE.
- p1 SB 0xA5 to 0x013 then LBU 0x013 -> p1_rdata=0x000000A5; LB 0x013 -> 0xFFFFFFA5.
- reset asserted during ACCESS of a p0 load -> no p0_rvalid afterward; all outputs 0 next cycle; the next tie goes to p0.
- With DMEM_ARB_ALIGN_CHK_EN, p0 LW at 0x012 -> MemRead stays 0, p0_rvalid with p0_err=1, rdata=0; without the macro -> MemRead=1, p0_err=0.
